pipe_issue_ctrl: RTL
====================

# pipe_issue_ctrl

Issue controller for the four-stage register/ALU/memory pipeline (`pipe`). It arbitrates round-robin between two instruction requesters and holds back any instruction that would read a register still being written by an in-flight instruction (RAW hazard). It drops instructions with illegal function codes and presents one registered instruction per cycle to the pipe's rs1/rs2/rd/func/addr inputs.

## Interface
- `REG_AW`, 4: register-index width (16-entry regbank).
- `FUNC_W`, 4: function-code width.
- `ADDR_W`, 8: memory-address width.
- `HAZ_WIN`, 2: number of issue cycles after an issue during which that instruction's rd blocks readers, 1..4.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1 (N=0,1): requester N presents an instruction.
- `reqN_ready` out 1: the instruction is consumed this cycle (combinational).
- `reqN_rs1`, `reqN_rs2`, `reqN_rd` in REG_AW: register indices.
- `reqN_func` in FUNC_W: operation code.
- `reqN_addr` in ADDR_W: result memory address.
- `flush` in 1: synchronous discard of the scoreboard and the issue register.
- `issue_valid` out 1: issue register holds a valid instruction.
- `issue_rs1`, `issue_rs2`, `issue_rd` out REG_AW; `issue_func` out FUNC_W; `issue_addr` out ADDR_W: fields to the pipe.
- `issue_src` out 1: requester index of the issued instruction.
- `err_illegal` out 1: one-cycle pulse when an illegal-func instruction is consumed.
- `issued_cnt` out 16: count of issued instructions, wraps at 65535→0.

## Operation
- Scoreboard: HAZ_WIN slots of {v, rd}.
  - slot0 is loaded each cycle with {issued-this-cycle, rd}.
  - slot[i] is loaded from slot[i-1].
- Hazard for requester N: `reqN_valid` and (rs1 or rs2 equals rd of any slot with v=1). rd-vs-rd (WAW) is not checked.
- Eligible: valid and no hazard.
- Arbitration: round-robin pointer `prio`, reset to requester 0.
  - If both requesters are eligible, grant `prio` and then set `prio` to the other requester.
  - If one is eligible, grant it and set `prio` to the other requester.
  - If none is eligible, `prio` is unchanged.
- `reqN_ready` = granted to N and not `flush`. At most one ready per cycle.
- Legal func: 0..11 (ADD, SUB, MUL, SELA, SELB, AND, OR, XOR, NEGA, NEGB, SRA, SLA).
- Granted legal instruction: load the issue register, set `issue_valid` and `issue_src`, enter the scoreboard, increment `issued_cnt`.
- Granted illegal instruction (func 12..15): consumed, not issued, not entered in the scoreboard. Pulse `err_illegal` the next cycle; `issue_valid`=0 that cycle.
- No grant: `issue_valid`=0 next cycle. Issue fields hold their last values.
- `flush`:
  - No grant that cycle.
  - Next cycle: all scoreboard v=0 and `issue_valid`=0.
  - `prio` and `issued_cnt` are unchanged.

## Timing
- Reset values: all outputs 0 (`issue_*`, `issue_src`, `err_illegal`, `issued_cnt`), all scoreboard v=0, `prio`=0. `reqN_ready` is 0 while `rst_n`=0.
- Asserting reset mid-stream discards the issue register and scoreboard immediately. There is no replay.
- Latency: a grant in cycle t gives `issue_valid`=1 in cycle t+1 (one register stage).
- Hazard window: an instruction granted in cycle t blocks readers of its rd in cycles t+1..t+HAZ_WIN. A dependent reader can be granted at t+HAZ_WIN+1 at the earliest.
- Handshake:
  - A requester holds valid and all fields stable until ready.
  - The instruction transfers in the cycle where valid=1 and ready=1.
  - ready may be 1 in consecutive cycles.
- Throughput: one issue per cycle when there is no hazard.
- Simultaneous events:
  - A hazard-blocked requester does not consume `prio`; the other requester may proceed.
  - `flush` in the same cycle as valid gives no grant.
  - A reader whose rs equals its own rd is not a hazard against itself.

## Structure
- Package `pipe_pkg` holds:
  - width localparams and the func code constants (ADD=0 … SLA=11);
  - `FUNC_MAX`=11;
  - an instruction struct {rs1, rs2, rd, func, addr}.
- Sub-module `rr_arb2`: 2-way round-robin arbiter (eligible[1:0] in, grant[1:0] out, internal `prio`).
- The scoreboard, issue register and counter stay inline.

## Test plan
- Independent stream: req0 sends 4 instructions back-to-back (rs1=3, rs2=5, rd=10, func=0, addr=125, …) → 4 consecutive `issue_valid` cycles starting one cycle after the first grant; `issued_cnt`=4.
- RAW stall: req0 (rs1=3, rs2=5, rd=10) granted at t, then req0 (rs1=10, rs2=5, rd=14) → ready=0 at t+1 and t+2, granted at t+3, issued at t+4.
- Fairness: both requesters permanently valid with no hazards → grants alternate 0,1,0,1; `issue_src` alternates.
- Bypass: req0 hazard-blocked on rd=12 while req1 is independent → req1 is granted in the blocked cycles; `prio` stays at req0 until req0 is granted.
- Illegal func: func=13 granted → ready=1, `err_illegal`=1 the next cycle, `issue_valid`=0, `issued_cnt` unchanged, no scoreboard entry (a later reader of that rd is not stalled).
- Flush and reset:
  - `flush` during a pending RAW stall → the stalled reader is granted in the cycle after the flush.
  - `rst_n` pulsed low mid-stream → all outputs 0 immediately, and the first grant after release goes to req0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared widths, function codes and instruction layout for the
//             register/ALU/memory pipe and its issue controller.
//  Contents : PIPE_* width localparams, func_e codes (ADD..SLA), FUNC_MAX,
//             instr_t instruction record.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int PIPE_REG_AW = 4;   // 16-entry register bank
    localparam int PIPE_FUNC_W = 4;
    localparam int PIPE_ADDR_W = 8;

    // Highest function code the ALU implements; codes above it are dropped.
    localparam int FUNC_MAX = 11;

    typedef enum logic [PIPE_FUNC_W-1:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        MUL  = 4'd2,
        SELA = 4'd3,
        SELB = 4'd4,
        AND  = 4'd5,
        OR   = 4'd6,
        XOR  = 4'd7,
        NEGA = 4'd8,
        NEGB = 4'd9,
        SRA  = 4'd10,
        SLA  = 4'd11
    } func_e;

    typedef struct packed {
        logic [PIPE_REG_AW-1:0] rs1;
        logic [PIPE_REG_AW-1:0] rs2;
        logic [PIPE_REG_AW-1:0] rd;
        logic [PIPE_FUNC_W-1:0] func;
        logic [PIPE_ADDR_W-1:0] addr;
    } instr_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin arbiter. When both inputs are eligible the
//             one pointed to by prio wins; after any grant prio moves to the
//             requester that was not granted. No grant leaves prio unchanged.
//  Ports    : clk, rst_n     - clock, async active-low reset (prio -> 0)
//             eligible[1:0]  - per-requester eligibility
//             grant[1:0]     - one-hot (or zero) grant, combinational
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic r_prio;   // requester favoured on a tie

    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Granting requester 0 hands priority to requester 1 and vice versa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (|grant) begin
            r_prio <= grant[0];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_issue_ctrl
//  Purpose  : Issue controller for the four-stage pipe. Arbitrates between two
//             requesters, stalls RAW hazards against recently issued rd's,
//             drops illegal function codes and presents one registered
//             instruction per cycle.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             reqN_valid/ready (N=0,1)   - valid/ready handshake
//             reqN_rs1/rs2/rd/func/addr  - requester instruction fields
//             flush                      - clear scoreboard and issue register
//             issue_valid, issue_*       - registered instruction to the pipe
//             issue_src                  - requester of the issued instruction
//             err_illegal                - pulse after an illegal func consumed
//             issued_cnt                 - wrapping count of issued instructions
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW  = PIPE_REG_AW,
    parameter int FUNC_W  = PIPE_FUNC_W,
    parameter int ADDR_W  = PIPE_ADDR_W,
    parameter int HAZ_WIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [REG_AW-1:0] req0_rs1,
    input  logic [REG_AW-1:0] req0_rs2,
    input  logic [REG_AW-1:0] req0_rd,
    input  logic [FUNC_W-1:0] req0_func,
    input  logic [ADDR_W-1:0] req0_addr,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [REG_AW-1:0] req1_rs1,
    input  logic [REG_AW-1:0] req1_rs2,
    input  logic [REG_AW-1:0] req1_rd,
    input  logic [FUNC_W-1:0] req1_func,
    input  logic [ADDR_W-1:0] req1_addr,

    input  logic              flush,

    output logic              issue_valid,
    output logic [REG_AW-1:0] issue_rs1,
    output logic [REG_AW-1:0] issue_rs2,
    output logic [REG_AW-1:0] issue_rd,
    output logic [FUNC_W-1:0] issue_func,
    output logic [ADDR_W-1:0] issue_addr,
    output logic              issue_src,
    output logic              err_illegal,
    output logic [15:0]       issued_cnt
);

    // ------------------------------------------------------------------
    // Scoreboard: slot0 holds the instruction issued last cycle, slot i the
    // one issued i+1 cycles ago. A valid slot blocks readers of its rd.
    // ------------------------------------------------------------------
    logic [HAZ_WIN-1:0]             r_sb_v;
    logic [HAZ_WIN-1:0][REG_AW-1:0] r_sb_rd;

    logic w_haz0;
    logic w_haz1;

    always_comb begin
        w_haz0 = 1'b0;
        w_haz1 = 1'b0;
        for (int i = 0; i < HAZ_WIN; i++) begin
            if (r_sb_v[i]) begin
                if ((req0_rs1 == r_sb_rd[i]) || (req0_rs2 == r_sb_rd[i])) begin
                    w_haz0 = 1'b1;
                end
                if ((req1_rs1 == r_sb_rd[i]) || (req1_rs2 == r_sb_rd[i])) begin
                    w_haz1 = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration. Masking eligibility (rather than the grant) during flush
    // or reset keeps the arbiter from advancing its priority pointer.
    // ------------------------------------------------------------------
    logic       w_allow;
    logic [1:0] w_elig;
    logic [1:0] w_grant;

    assign w_allow = rst_n & ~flush;
    assign w_elig  = {req1_valid & ~w_haz1, req0_valid & ~w_haz0} & {2{w_allow}};

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (w_elig),
        .grant    (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    // ------------------------------------------------------------------
    // Granted-instruction select and legality.
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] w_sel_rs1;
    logic [REG_AW-1:0] w_sel_rs2;
    logic [REG_AW-1:0] w_sel_rd;
    logic [FUNC_W-1:0] w_sel_func;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_any;
    logic              w_legal;
    logic              w_issue;
    logic              w_illegal;

    assign w_sel_rs1  = w_grant[1] ? req1_rs1  : req0_rs1;
    assign w_sel_rs2  = w_grant[1] ? req1_rs2  : req0_rs2;
    assign w_sel_rd   = w_grant[1] ? req1_rd   : req0_rd;
    assign w_sel_func = w_grant[1] ? req1_func : req0_func;
    assign w_sel_addr = w_grant[1] ? req1_addr : req0_addr;

    assign w_any     = |w_grant;
    assign w_legal   = (w_sel_func <= FUNC_W'(FUNC_MAX));
    assign w_issue   = w_any & w_legal;
    assign w_illegal = w_any & ~w_legal;

    // ------------------------------------------------------------------
    // Scoreboard shift. Flush clears every valid bit; rd values may carry
    // stale data since v alone qualifies them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_v  <= '0;
            r_sb_rd <= '0;
        end else begin
            r_sb_rd[0] <= w_sel_rd;
            for (int i = 1; i < HAZ_WIN; i++) begin
                r_sb_rd[i] <= r_sb_rd[i-1];
            end
            if (flush) begin
                r_sb_v <= '0;
            end else begin
                r_sb_v[0] <= w_issue;
                for (int i = 1; i < HAZ_WIN; i++) begin
                    r_sb_v[i] <= r_sb_v[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue register, error pulse and issue counter. issue_valid follows
    // w_issue directly: a flush cycle never grants, so it clears naturally.
    // ------------------------------------------------------------------
    logic              r_issue_valid;
    logic [REG_AW-1:0] r_issue_rs1;
    logic [REG_AW-1:0] r_issue_rs2;
    logic [REG_AW-1:0] r_issue_rd;
    logic [FUNC_W-1:0] r_issue_func;
    logic [ADDR_W-1:0] r_issue_addr;
    logic              r_issue_src;
    logic              r_err_illegal;
    logic [15:0]       r_issued_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_issue_rs1   <= '0;
            r_issue_rs2   <= '0;
            r_issue_rd    <= '0;
            r_issue_func  <= '0;
            r_issue_addr  <= '0;
            r_issue_src   <= 1'b0;
            r_err_illegal <= 1'b0;
            r_issued_cnt  <= '0;
        end else begin
            r_issue_valid <= w_issue;
            r_err_illegal <= w_illegal;
            if (w_issue) begin
                r_issue_rs1  <= w_sel_rs1;
                r_issue_rs2  <= w_sel_rs2;
                r_issue_rd   <= w_sel_rd;
                r_issue_func <= w_sel_func;
                r_issue_addr <= w_sel_addr;
                r_issue_src  <= w_grant[1];
                r_issued_cnt <= r_issued_cnt + 16'd1;
            end
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_rs1   = r_issue_rs1;
    assign issue_rs2   = r_issue_rs2;
    assign issue_rd    = r_issue_rd;
    assign issue_func  = r_issue_func;
    assign issue_addr  = r_issue_addr;
    assign issue_src   = r_issue_src;
    assign err_illegal = r_err_illegal;
    assign issued_cnt  = r_issued_cnt;

endmodule : pipe_issue_ctrl
`default_nettype wire
